// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache line refill controller.
package cache_refill_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned LINE_SIZE_DEF  = 512;
  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned LEN_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FILL  = 2'd2,
    ST_WRITE = 2'd3
  } refill_state_e;

  // Number of bus beats that make up one cache line.
  function automatic int unsigned beats_of(input int unsigned line_bits,
                                           input int unsigned word_bits);
    return line_bits / word_bits;
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Miss request, memory read bus and data-array write port of the refill controller.
interface cache_refill_ctrl_if
  import cache_refill_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned Cache_line_size = LINE_SIZE_DEF,
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF
);

  logic                       miss_valid;
  logic                       miss_ready;
  logic [ADDR_WIDTH-1:0]      miss_addr;
  logic                       rd_req_valid;
  logic                       rd_req_ready;
  logic [ADDR_WIDTH-1:0]      rd_req_addr;
  logic [LEN_W-1:0]           rd_req_len;
  logic                       rd_data_valid;
  logic                       rd_data_ready;
  logic [DATA_WIDTH-1:0]      rd_data;
  logic                       rd_data_last;
  logic                       crit_valid;
  logic [DATA_WIDTH-1:0]      crit_data;
  logic                       line_wen;
  logic [ADDR_WIDTH-1:0]      line_addr;
  logic [Cache_line_size-1:0] line_data;
  logic                       busy;

  // Controller side
  modport master (
    input  miss_valid, miss_addr, rd_req_ready, rd_data_valid, rd_data, rd_data_last,
    output miss_ready, rd_req_valid, rd_req_addr, rd_req_len, rd_data_ready,
           crit_valid, crit_data, line_wen, line_addr, line_data, busy
  );

  // Cache / memory side
  modport slave (
    output miss_valid, miss_addr, rd_req_ready, rd_data_valid, rd_data, rd_data_last,
    input  miss_ready, rd_req_valid, rd_req_addr, rd_req_len, rd_data_ready,
           crit_valid, crit_data, line_wen, line_addr, line_data, busy
  );

endinterface

// File: rtl/cache_refill_ctrl_line_buf.sv
// Line assembly buffer: BEATS words, bulk clear, indexed word write, flat read.
module refill_line_buf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BEATS      = 16,
  parameter int unsigned IDX_W      = $clog2(BEATS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        wen,
  input  logic [IDX_W-1:0]            idx,
  input  logic [DATA_WIDTH-1:0]       wdata,
  output logic [BEATS*DATA_WIDTH-1:0] line
);

  logic [BEATS-1:0][DATA_WIDTH-1:0] words;

  // Word i lands at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
  assign line = words;

  // Clear has priority so a new refill never inherits a stale word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words <= '0;
    end else if (clr) begin
      words <= '0;
    end else if (wen) begin
      words[idx] <= wdata;
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache line refill sequencer: burst request, beat assembly, critical word forward, line write.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned Cache_line_size = LINE_SIZE_DEF,
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_refill_ctrl_if.master  bus
);

  localparam int unsigned BEATS    = beats_of(Cache_line_size, DATA_WIDTH);
  localparam int unsigned OFFSET_W = $clog2(BEATS);
  localparam int unsigned WORD_LSB = $clog2(DATA_WIDTH / 8);
  localparam int unsigned LINE_LSB = $clog2(Cache_line_size / 8);
  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(BEATS - 1);

  refill_state_e         state;
  logic [OFFSET_W-1:0]   beat_cnt;
  logic [OFFSET_W-1:0]   crit_off;
  logic [ADDR_WIDTH-1:0] line_addr_q;
  logic                  miss_take;
  logic                  beat_take;
  logic                  addr_unused;

  // Byte-within-word bits never matter to a line refill
  assign addr_unused = ^bus.miss_addr[WORD_LSB-1:0];

  assign miss_take = bus.miss_valid & bus.miss_ready;
  // rd_data_ready is only high in FILL, so this is the FILL beat handshake
  assign beat_take = bus.rd_data_valid & bus.rd_data_ready;

  assign bus.rd_req_addr = line_addr_q;
  assign bus.rd_req_len  = LEN_W'(BEATS - 1);
  assign bus.line_addr   = line_addr_q;

  refill_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BEATS      (BEATS),
    .IDX_W      (OFFSET_W)
  ) u_line_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (miss_take),
    .wen   (beat_take),
    .idx   (beat_cnt),
    .wdata (bus.rd_data),
    .line  (bus.line_data)
  );

  // Refill FSM with beat counter and registered handshake/strobe outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      beat_cnt          <= '0;
      crit_off          <= '0;
      line_addr_q       <= '0;
      bus.miss_ready    <= 1'b1;
      bus.rd_req_valid  <= 1'b0;
      bus.rd_data_ready <= 1'b0;
      bus.crit_valid    <= 1'b0;
      bus.crit_data     <= '0;
      bus.line_wen      <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      bus.crit_valid <= 1'b0;
      bus.line_wen   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (miss_take) begin
            line_addr_q      <= {bus.miss_addr[ADDR_WIDTH-1:LINE_LSB], LINE_LSB'(0)};
            crit_off         <= bus.miss_addr[WORD_LSB +: OFFSET_W];
            beat_cnt         <= '0;
            bus.miss_ready   <= 1'b0;
            bus.rd_req_valid <= 1'b1;
            bus.busy         <= 1'b1;
            state            <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.rd_req_ready) begin
            bus.rd_req_valid  <= 1'b0;
            bus.rd_data_ready <= 1'b1;
            state             <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (beat_take) begin
            if (beat_cnt == crit_off) begin
              bus.crit_valid <= 1'b1;
              bus.crit_data  <= bus.rd_data;
            end
            // Stop on an early last, or after the final slot even without last
            if (bus.rd_data_last || (beat_cnt == LAST_BEAT)) begin
              beat_cnt          <= '0;
              bus.rd_data_ready <= 1'b0;
              bus.line_wen      <= 1'b1;
              state             <= ST_WRITE;
            end else begin
              beat_cnt <= beat_cnt + OFFSET_W'(1);
            end
          end
        end
        ST_WRITE: begin
          bus.miss_ready <= 1'b1;
          bus.busy       <= 1'b0;
          state          <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
